// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA pixel/line timing generator with sync, blanking and frame strobes
module vga_sync_gen #(
  parameter int DIV    = 2,
  parameter int H_DISP = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_DISP = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_tick,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_LAST = 4'(DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_START = 10'(H_DISP + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISP + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_DISP + V_FP + V_SYNC - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISP);
  localparam logic [9:0] V_VIS    = 10'(V_DISP);
  localparam logic [9:0] FT_LINE  = 10'(V_DISP + 1);

  logic [3:0] divider_q, divider_d;
  logic [9:0] pixel_x_q, pixel_x_d;
  logic [9:0] pixel_y_q, pixel_y_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       tick;
  logic       frame_hit;

  always_comb begin
    tick      = (divider_q == DIV_LAST);
    divider_d = tick ? 4'd0 : divider_q + 4'd1;

    pixel_x_d = pixel_x_q;
    pixel_y_d = pixel_y_q;
    if (tick) begin
      if (pixel_x_q == H_LAST) begin
        pixel_x_d = 10'd0;
        pixel_y_d = (pixel_y_q == V_LAST) ? 10'd0 : pixel_y_q + 10'd1;
      end else begin
        pixel_x_d = pixel_x_q + 10'd1;
      end
    end

    // Decoding the next-state counters lets the flopped syncs line up with pixel_x/pixel_y.
    hsync_d    = !((pixel_x_d >= HS_START) && (pixel_x_d <= HS_END));
    vsync_d    = !((pixel_y_d >= VS_START) && (pixel_y_d <= VS_END));
    video_on_d = (pixel_x_d < H_VIS) && (pixel_y_d < V_VIS);

    frame_hit   = tick && (pixel_x_q == 10'd0) && (pixel_y_q == FT_LINE);
    frame_cnt_d = frame_hit ? frame_cnt_q + 8'd1 : frame_cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divider_q   <= 4'd0;
      pixel_x_q   <= 10'd0;
      pixel_y_q   <= 10'd0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      video_on_q  <= 1'b1;
      frame_cnt_q <= 8'd0;
    end else begin
      divider_q   <= divider_d;
      pixel_x_q   <= pixel_x_d;
      pixel_y_q   <= pixel_y_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      video_on_q  <= video_on_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign p_tick     = tick;
  assign pixel_x    = pixel_x_q;
  assign pixel_y    = pixel_y_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign video_on   = video_on_q;
  assign frame_tick = frame_hit;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - randomized-reset bench for vga_sync_gen at DIV 1/2/4 on a shrunken raster
module tb_vga_sync_gen;

  localparam int HD = 4, HF = 1, HS = 2, HB = 1;
  localparam int VD = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;

  typedef struct packed {
    logic       pt;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       vo;
    logic       ft;
    logic [7:0] fc;
  } obs_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_vec;
  int   n_bad;

  obs_t o1, o2, o4;

  vga_sync_gen #(.DIV(1), .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                 .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) u_dut1 (
    .clk(clk), .reset(reset), .p_tick(o1.pt), .pixel_x(o1.x), .pixel_y(o1.y),
    .hsync(o1.hs), .vsync(o1.vs), .video_on(o1.vo), .frame_tick(o1.ft), .frame_cnt(o1.fc));

  vga_sync_gen #(.DIV(2), .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                 .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) u_dut2 (
    .clk(clk), .reset(reset), .p_tick(o2.pt), .pixel_x(o2.x), .pixel_y(o2.y),
    .hsync(o2.hs), .vsync(o2.vs), .video_on(o2.vo), .frame_tick(o2.ft), .frame_cnt(o2.fc));

  vga_sync_gen #(.DIV(4), .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                 .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) u_dut4 (
    .clk(clk), .reset(reset), .p_tick(o4.pt), .pixel_x(o4.x), .pixel_y(o4.y),
    .hsync(o4.hs), .vsync(o4.vs), .video_on(o4.vo), .frame_tick(o4.ft), .frame_cnt(o4.fc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs after c clk edges out of reset: the raster is just the pixel count p = c/div.
  function automatic obs_t model(int c, int div);
    obs_t e;
    int   p, first, nft;
    p     = c / div;
    e.pt  = (c % div) == (div - 1);
    e.x   = 10'(p % HT);
    e.y   = 10'((p / HT) % VT);
    e.hs  = !((int'(e.x) >= HD + HF) && (int'(e.x) < HD + HF + HS));
    e.vs  = !((int'(e.y) >= VD + VF) && (int'(e.y) < VD + VF + VS));
    e.vo  = (int'(e.x) < HD) && (int'(e.y) < VD);
    e.ft  = e.pt && (e.x == 10'd0) && (int'(e.y) == VD + 1);
    first = (VD + 1) * HT;
    nft   = (p > first) ? (p - 1 - first) / (HT * VT) + 1 : 0;
    e.fc  = 8'(nft % 256);
    return e;
  endfunction

  task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_inst(string tag, obs_t o, int div);
    obs_t e;
    e = model(cyc, div);
    check_eq($sformatf("%s_d%0d_p_tick", tag, div), 32'(o.pt), 32'(e.pt));
    check_eq($sformatf("%s_d%0d_pixel_x", tag, div), 32'(o.x), 32'(e.x));
    check_eq($sformatf("%s_d%0d_pixel_y", tag, div), 32'(o.y), 32'(e.y));
    check_eq($sformatf("%s_d%0d_hsync", tag, div), 32'(o.hs), 32'(e.hs));
    check_eq($sformatf("%s_d%0d_vsync", tag, div), 32'(o.vs), 32'(e.vs));
    check_eq($sformatf("%s_d%0d_video_on", tag, div), 32'(o.vo), 32'(e.vo));
    check_eq($sformatf("%s_d%0d_frame_tick", tag, div), 32'(o.ft), 32'(e.ft));
    check_eq($sformatf("%s_d%0d_frame_cnt", tag, div), 32'(o.fc), 32'(e.fc));
  endtask

  task automatic check_all(string tag);
    check_inst(tag, o1, 1);
    check_inst(tag, o2, 2);
    check_inst(tag, o4, 4);
  endtask

  task automatic run_cycle(string tag);
    @(posedge clk);
    if (!reset) cyc++;
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    cyc   = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_all("rst");
    reset = 1'b0;

    // Random async reset pulses land mid-line and mid-frame, including inside sync windows.
    for (int i = 0; i < 3000; i++) begin
      run_cycle("run");
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
        cyc = 0;
        #1 check_all("async");
        @(negedge clk);
        check_all("hold");
        reset = 1'b0;
      end
    end

    // Long undisturbed run: DIV=1 passes 256 frames so frame_cnt wraps 255 -> 0.
    #2 reset = 1'b1;
    cyc = 0;
    #1 check_all("async");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 13000; i++) begin
      run_cycle("long");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
